// File: rtl/and_result_buffer.sv
// Result buffer for the clocked AND stage: captures result bytes (every sample or
// only on change) into a small show-ahead FIFO and tracks lost captures.
module and_result_buffer #(
    parameter int unsigned DEPTH = 4,  // power of two, 2..16
    parameter int unsigned W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [W-1:0]               y_in,
    input  logic                       y_valid,
    input  logic                       capture_mode,
    input  logic                       clr,
    input  logic                       rd_en,
    output logic [W-1:0]               dout,
    output logic                       dout_valid,
    output logic [$clog2(W):0]         popcnt,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned PW = $clog2(W) + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [W-1:0]  last_y_q;
    logic          last_seen_q;
    logic          overflow_q;
    logic [7:0]    drop_cnt_q;

    logic          cap_req, do_pop, do_push, do_drop, full_c, empty_c;
    logic [W-1:0]  dout_c;
    logic [PW-1:0] popcnt_c;

    // Capture decision compares against last_y before this cycle's update.
    always_comb begin
        full_c  = (count_q == DepthC);
        empty_c = (count_q == '0);
        cap_req = y_valid && (!capture_mode || !last_seen_q || (y_in != last_y_q));
        do_pop  = rd_en && !empty_c;
        // A same-cycle pop frees the slot, so a full FIFO still accepts the write.
        do_push = cap_req && (!full_c || do_pop);
        do_drop = cap_req && full_c && !do_pop;
    end

    // Show-ahead head byte, forced to zero when empty, and its population count.
    always_comb begin
        dout_c   = empty_c ? '0 : mem_q[rd_ptr_q];
        popcnt_c = '0;
        for (int i = 0; i < int'(W); i++) begin
            popcnt_c = popcnt_c + PW'(dout_c[i]);
        end
    end

    // Entry storage; contents beyond the occupied range are never observed.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem_q[wr_ptr_q] <= y_in;
        end
    end

    // Pointers, occupancy, change-detect history and loss bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_y_q    <= '0;
            last_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else if (clr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_seen_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            if (y_valid) begin
                last_y_q    <= y_in;
                last_seen_q <= 1'b1;
            end
            // Power-of-two depth lets the pointers wrap naturally.
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
            if (do_drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_q <= drop_cnt_q + 8'd1;
                end
            end
        end
    end

    assign dout       = dout_c;
    assign dout_valid = !empty_c;
    assign popcnt     = popcnt_c;
    assign count      = count_q;
    assign full       = full_c;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
